dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: port A (pipeline
//  memory-access stage, LW/SW) and port B (loader/debug DMA). Round-robin
//  arbitration with an optional bounded lock for port B bursts. Checks
//  alignment and range, and routes the 1-cycle-latency read data back to the
//  winner. Sits between the memory-access stage / loader and the DMem array.
// PARAMETERS
//  DATA_W    32    data word width
//  ADDR_W    32    byte-address width of both request ports
//  DEPTH     1024  memory depth in words; valid word index 0..DEPTH-1
//  MAX_LOCK  8     max consecutive B grants under lock while A is requesting
// PORTS
//  CLK        in   1       clock, rising edge
//  RST        in   1       asynchronous reset, active-low (0 = reset)
//  a_req      in   1       port A request; held with fields until a_gnt
//  a_we       in   1       port A write (1) / read (0)
//  a_addr     in   ADDR_W  port A byte address
//  a_wdata    in   DATA_W  port A write data
//  a_gnt      out  1       port A request accepted this cycle
//  a_rvalid   out  1       port A read data/error valid (cycle after grant)
//  a_rdata    out  DATA_W  port A read data
//  a_err      out  1       port A access rejected (misaligned/out of range), with a_rvalid
//  b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err: as port A, port B
//  b_lock     in   1       B wants back-to-back grants (burst)
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       memory write enable
//  mem_idx    out  ADDR_W-2 word index (byte address >> 2)
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid cycle after mem_en & ~mem_we
// BEHAVIOUR
//  - Reset (RST=0, async): all outputs 0; last_gnt=B (so A wins first tie);
//    lock_cnt=0; state IDLE. Pending rvalids are dropped.
//  - Arbitration (combinational, per cycle): only one requester -> it wins.
//    Both -> winner is the port not granted last, except LOCK state below.
//  - gnt pulses 1 cycle for the winner; requester drops/changes req after gnt.
//  - Legal access: addr[1:0]==0 and (addr>>2)<DEPTH. Legal -> mem_en=1 same
//    cycle, mem_we=we, mem_idx=addr>>2, mem_wdata=wdata. Illegal -> gnt still
//    given, mem_en=0, no write.
//  - Response (registered, 1 cycle after gnt): rvalid=1 for reads AND writes;
//    read: rdata=mem_rdata; write: rdata=wdata (store data echo, matches
//    writeback mux); illegal: err=1, rdata=0. rvalid/err are 1-cycle pulses.
//  - States: IDLE (last grant was A or none), LAST_B, LOCK.
//    LAST_B -> LOCK when B granted with b_lock=1. In LOCK B wins ties while
//    b_lock=1 and lock_cnt<MAX_LOCK; lock_cnt increments on each B grant made
//    while a_req=1, saturates at MAX_LOCK. lock_cnt==MAX_LOCK with a_req=1 ->
//    A granted, lock_cnt=0, -> IDLE. b_lock=0 or B idle -> leave LOCK
//    (IDLE if A granted, else LAST_B), lock_cnt=0.
//  - Throughput: one grant per cycle, no bubbles; back-to-back same-port OK.
//  - No req on either port -> mem_en=0, state/last_gnt unchanged.
//  - Same-address write then read from different ports on consecutive cycles:
//    read sees the new data (memory write-first at edge).
// TESTING
//  - A read 0x10 alone: a_gnt cycle 0, mem_idx=4, a_rvalid+mem_rdata cycle 1.
//  - A and B request every cycle, no lock -> grants alternate A,B,A,B from reset.
//  - B lock burst, A requests throughout, MAX_LOCK=8 -> 8 B grants then A granted.
//  - A write 0x3 -> a_gnt, mem_en=0, a_err=1 next cycle; addr 4*DEPTH -> a_err.
//  - B writes 0xDEADBEEF @0x20, A reads 0x20 next cycle -> a_rdata=0xDEADBEEF.
//  - RST low mid-burst (pending read) -> outputs 0 at once, no rvalid, A wins next tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module  : dmem_arbiter
// Purpose : Round-robin arbiter sharing one single-port data memory between
//           the pipeline (port A) and a loader/DMA (port B), with B burst lock.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_idx,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAST_B = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               last_b, last_b_nxt;
    logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;

    logic               lock_hold;
    logic               win_a, win_b, any_gnt;
    logic               sel_we, legal;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    logic               rsp_valid, rsp_b, rsp_read, rsp_err;
    logic [DATA_W-1:0]  rsp_data, rdata_mux;

    assign lock_hold = (state == LOCK) && b_lock && (lock_cnt < CNT_W'(MAX_LOCK));

    always_comb begin
        win_a = 1'b0;
        win_b = 1'b0;
        if (a_req && b_req) begin
            if (lock_hold || !last_b)
                win_b = 1'b1;
            else
                win_a = 1'b1;
        end else begin
            win_a = a_req;
            win_b = b_req;
        end
    end

    // Grants are masked while reset is asserted so every output drops at once.
    assign a_gnt   = win_a & rst_n;
    assign b_gnt   = win_b & rst_n;
    assign any_gnt = a_gnt | b_gnt;

    assign sel_we    = win_b ? b_we    : a_we;
    assign sel_addr  = win_b ? b_addr  : a_addr;
    assign sel_wdata = win_b ? b_wdata : a_wdata;
    assign legal     = (sel_addr[1:0] == 2'b00) &&
                       ({2'b00, sel_addr[ADDR_W-1:2]} < ADDR_W'(DEPTH));

    assign mem_en    = any_gnt & legal;
    assign mem_we    = mem_en & sel_we;
    assign mem_idx   = mem_en ? sel_addr[ADDR_W-1:2] : '0;
    assign mem_wdata = mem_en ? sel_wdata : '0;

    always_comb begin
        state_nxt    = state;
        last_b_nxt   = last_b;
        lock_cnt_nxt = lock_cnt;
        if (win_a) begin
            state_nxt    = IDLE;
            last_b_nxt   = 1'b0;
            lock_cnt_nxt = '0;
        end else if (win_b) begin
            last_b_nxt = 1'b1;
            if (b_lock) begin
                state_nxt = LOCK;
                if (state != LOCK)
                    lock_cnt_nxt = a_req ? CNT_W'(1) : '0;
                else if (a_req && (lock_cnt < CNT_W'(MAX_LOCK)))
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end else begin
                state_nxt    = LAST_B;
                lock_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last_b   <= last_b_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Writes echo their store data; reads take the memory output one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_b     <= 1'b0;
            rsp_read  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= any_gnt;
            rsp_b     <= win_b;
            rsp_read  <= any_gnt & legal & ~sel_we;
            rsp_err   <= any_gnt & ~legal;
            rsp_data  <= (any_gnt & legal & sel_we) ? sel_wdata : '0;
        end
    end

    assign rdata_mux = rsp_read ? mem_rdata : rsp_data;

    assign a_rvalid = rsp_valid & ~rsp_b;
    assign a_err    = rsp_err & ~rsp_b;
    assign a_rdata  = a_rvalid ? rdata_mux : '0;
    assign b_rvalid = rsp_valid & rsp_b;
    assign b_err    = rsp_err & rsp_b;
    assign b_rdata  = b_rvalid ? rdata_mux : '0;

endmodule

`default_nettype wire
